mc_control_unit_ws: RTL
=======================

Name: mc_control_unit_ws

Overview:
- Parametrised multi-cycle control FSM for the 16-bit TSC datapath; next generation of the existing multi-cycle control unit.
- Adds memory wait-state handshake (mem_ready), bounded wait with timeout error, a sticky HALT state and a retired-instruction counter.
- Sits between the IR/opcode decode and the multi-cycle datapath (PC, IR, MDR, A/B, ALUOut registers, register file, memory port).

Parameters:
- CNT_WIDTH, 16, width of retired-instruction counter num_inst.
- MAX_WAIT, 15, maximum consecutive mem_ready-low cycles tolerated in any memory access; must be >=1.
- WAIT_W, 4, width of the internal wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- opcode  in  4  IR[15:12].
- funccode  in  6  IR[5:0].
- bcond  in  1  branch condition from ALU, valid in EXE.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write, pc_write_not_cond, i_or_d, mem_read, mem_write, ir_write, mdr_write, alu_src_A, reg_write, A_write, B_write, alu_write  out  1 each  datapath strobes/selects, with the same meaning as in the current unit.
- alu_src_B, reg_dst, mem_to_reg, pc_src  out  2 each  datapath mux selects (codes from opcodes.v).
- alu_op  out  3  ALU function.
- is_halted  out  1  high while in HALT.
- mem_error  out  1  sticky timeout flag.
- num_inst  out  CNT_WIDTH  retired-instruction count.
- state_o  out  3  current state, for debug.

Behaviour:
- States and encodings: IF=0, ID=1, EXE=2, MEM=3, WB=4, PCUP=5, HALT=6. Encoding 7 is illegal and goes to HALT.
- Opcodes: BNE=0, BEQ=1, BGZ=2, BLZ=3, ADI=4, ORI=5, LHI=6, LWD=7, SWD=8, JMP=9, JAL=10, ALU=15.
- Funccodes: JPR=25, JRL=26, WWD=28, HLT=29.
- Reset (reset_n=0 at posedge): state=IF, num_inst=0, mem_error=0, wait_cnt=0. All strobes are 0 during reset and in HALT. Reset overrides any state, including an in-flight MEM or a wait.
- Outputs are combinational from state, opcode, funccode, bcond and mem_ready. Every output has a defined value in every state (no latches). Unused selects are 0.
- IF:
  - mem_read=1, i_or_d=0; ir_write=mem_ready.
  - Stay in IF while mem_ready=0; go to ID on mem_ready=1.
- ID:
  - A_write=B_write=1.
  - Branch: ALUOut=PC+imm via alu_src_A=PC, alu_src_B=IMM, alu_op=ADD, alu_write=1.
  - opcode=ALU with func=HLT -> HALT. HLT is not counted.
  - LHI, JAL, JRL -> WB. JMP, JPR, WWD -> PCUP. All others -> EXE.
- EXE:
  - Branch: alu_op=SUB, src_B=B for BNE/BEQ and 0 for BGZ/BLZ -> PCUP.
  - ALU R-type: alu_op=funccode[2:0], alu_write=1 -> WB.
  - ADI/LWD/SWD: ADD with IMM. ORI: ORR with IMM. Then LWD/SWD -> MEM, else -> WB.
- MEM:
  - i_or_d=1. LWD: mem_read=1, mdr_write=mem_ready. SWD: mem_write=1.
  - Stay in MEM until mem_ready=1, then LWD -> WB, SWD -> PCUP.
- WB:
  - reg_write=1. Destination and source: RT/ALUOut for ADI/ORI, RT/IMM for LHI, RT/MDR for LWD, reg 2/PC for JAL/JRL, RD/ALUOut otherwise.
  - Next state: PCUP.
- PCUP:
  - pc_write=1. JMP/JAL: pc_src=Target. JPR/JRL: pc_src=A.
  - Branch taken (bcond registered in EXE): pc_src=ALUOut. Otherwise pc_src=ALURes with PC+1.
  - num_inst increments by 1 here, wrapping at 2^CNT_WIDTH.
  - Next state: IF.
- Wait counter:
  - Increments on each cycle in IF or MEM with mem_ready=0; clears on mem_ready=1 or on any state change.
  - If it reaches MAX_WAIT while mem_ready is still 0: mem_error<=1 and go to HALT on the next edge. No further strobes are issued.
  - mem_ready=1 on the same cycle the counter hits MAX_WAIT means completion wins.
- HALT: absorbing until reset; is_halted=1; num_inst is frozen.

Optional Feature:
- Macro MC_FAST_BRANCH_EN.
- Defined: branches finish in EXE with pc_write=1. Taken: pc_src=ALUOut. Not taken: pc_src=ALURes with alu_src_A=PC, alu_src_B=1, ADD reusing the ALU. num_inst increments in EXE and the next state is IF, so a branch takes 3 states (IF, ID, EXE) when mem_ready is held high.
- Undefined: branches go through PCUP as described above (4 states).

Test Plan:
- ADI with mem_ready tied to 1 -> state sequence 0,1,2,4,5,0; reg_write=1 only in WB; num_inst 0->1.
- LWD with mem_ready low for 3 cycles in MEM -> MEM held 4 cycles, mdr_write=1 only on the ready cycle; 6+3 cycles total; mem_error=0.
- IF with mem_ready low for 15 cycles (MAX_WAIT=15) -> mem_error=1, state_o=6, is_halted=1; num_inst unchanged thereafter.
- BEQ taken (bcond=1) vs not taken -> pc_src=ALUOut vs ALURes in PCUP; with MC_FAST_BRANCH_EN the same selects appear in EXE, 3 states total.
- HLT (opcode 15, func 29) after 5 retired instructions -> HALT with num_inst=5; reset_n=0 for 1 cycle -> state_o=0, num_inst=0, mem_error=0.
- Reset asserted mid-MEM on an SWD -> mem_write drops in the reset cycle and the FSM restarts in IF.

Source files
------------

// File: rtl/mc_control_unit_ws_if.sv
// ============================================================================
// Module      : mc_control_unit_ws_if
// Description : Decode-side inputs and datapath strobes/selects of the
//               multi-cycle TSC control unit, with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_control_unit_ws_if #(
    parameter int CNT_WIDTH = 16
);
    logic [3:0]           opcode;
    logic [5:0]           funccode;
    logic                 bcond;
    logic                 mem_ready;

    logic                 pc_write;
    logic                 pc_write_not_cond;
    logic                 i_or_d;
    logic                 mem_read;
    logic                 mem_write;
    logic                 ir_write;
    logic                 mdr_write;
    logic                 alu_src_A;
    logic                 reg_write;
    logic                 A_write;
    logic                 B_write;
    logic                 alu_write;
    logic [1:0]           alu_src_B;
    logic [1:0]           reg_dst;
    logic [1:0]           mem_to_reg;
    logic [1:0]           pc_src;
    logic [2:0]           alu_op;
    logic                 is_halted;
    logic                 mem_error;
    logic [CNT_WIDTH-1:0] num_inst;
    logic [2:0]           state_o;

    modport master (
        input  opcode, funccode, bcond, mem_ready,
        output pc_write, pc_write_not_cond, i_or_d, mem_read, mem_write,
               ir_write, mdr_write, alu_src_A, reg_write, A_write, B_write,
               alu_write, alu_src_B, reg_dst, mem_to_reg, pc_src, alu_op,
               is_halted, mem_error, num_inst, state_o
    );

    modport slave (
        output opcode, funccode, bcond, mem_ready,
        input  pc_write, pc_write_not_cond, i_or_d, mem_read, mem_write,
               ir_write, mdr_write, alu_src_A, reg_write, A_write, B_write,
               alu_write, alu_src_B, reg_dst, mem_to_reg, pc_src, alu_op,
               is_halted, mem_error, num_inst, state_o
    );
endinterface

`default_nettype wire

// File: rtl/mc_control_unit_ws.sv
// ============================================================================
// Module      : mc_control_unit_ws
// Description : Multi-cycle TSC control FSM with memory wait states, bounded
//               wait timeout, sticky HALT and retired-instruction counter.
//               Optional macro MC_FAST_BRANCH_EN: branches complete in EXE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_unit_ws #(
    parameter int CNT_WIDTH = 16,
    parameter int MAX_WAIT  = 15,
    parameter int WAIT_W    = 4
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    mc_control_unit_ws_if.master   bus
);
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_PCUP = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [3:0] OP_BNE = 4'd0,  OP_BEQ = 4'd1,  OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5,  OP_LHI = 4'd6,  OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8,  OP_JMP = 4'd9,  OP_JAL = 4'd10;
    localparam logic [3:0] OP_ALU = 4'd15, OP_BLZ = 4'd3;
    localparam logic [5:0] FN_JPR = 6'd25, FN_JRL = 6'd26, FN_WWD = 6'd28, FN_HLT = 6'd29;

    // Mux select codes shared with the datapath
    localparam logic       SRCA_PC  = 1'b0, SRCA_A = 1'b1;
    localparam logic [1:0] SRCB_B   = 2'd0, SRCB_ONE = 2'd1, SRCB_IMM = 2'd2, SRCB_ZERO = 2'd3;
    localparam logic [1:0] DST_RD   = 2'd0, DST_RT = 2'd1, DST_R2 = 2'd2;
    localparam logic [1:0] M2R_ALU  = 2'd0, M2R_MDR = 2'd1, M2R_IMM = 2'd2, M2R_PC = 2'd3;
    localparam logic [1:0] PCS_ALURES = 2'd0, PCS_ALUOUT = 2'd1, PCS_TARGET = 2'd2, PCS_A = 2'd3;
    localparam logic [2:0] ALU_ADD  = 3'd0, ALU_SUB = 3'd1, ALU_ORR = 3'd3;

    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  mem_error_q, mem_error_d;
    logic                  bcond_q, bcond_d;
    logic [CNT_WIDTH-1:0]  num_inst_q, num_inst_d;
    logic                  mem_phase;

    logic is_branch, is_rtype, is_jpr, is_jrl, is_wwd, is_hlt;
    assign is_branch = (bus.opcode <= OP_BLZ);
    assign is_rtype  = (bus.opcode == OP_ALU);
    assign is_jpr    = is_rtype && (bus.funccode == FN_JPR);
    assign is_jrl    = is_rtype && (bus.funccode == FN_JRL);
    assign is_wwd    = is_rtype && (bus.funccode == FN_WWD);
    assign is_hlt    = is_rtype && (bus.funccode == FN_HLT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IF;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
            bcond_q     <= 1'b0;
            num_inst_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            bcond_q     <= bcond_d;
            num_inst_q  <= num_inst_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        wait_cnt_d            = '0;
        mem_error_d           = mem_error_q;
        bcond_d               = bcond_q;
        num_inst_d            = num_inst_q;
        mem_phase             = 1'b0;
        bus.pc_write          = 1'b0;
        bus.pc_write_not_cond = 1'b0;
        bus.i_or_d            = 1'b0;
        bus.mem_read          = 1'b0;
        bus.mem_write         = 1'b0;
        bus.ir_write          = 1'b0;
        bus.mdr_write         = 1'b0;
        bus.alu_src_A         = SRCA_PC;
        bus.reg_write         = 1'b0;
        bus.A_write           = 1'b0;
        bus.B_write           = 1'b0;
        bus.alu_write         = 1'b0;
        bus.alu_src_B         = SRCB_B;
        bus.reg_dst           = DST_RD;
        bus.mem_to_reg        = M2R_ALU;
        bus.pc_src            = PCS_ALURES;
        bus.alu_op            = ALU_ADD;

        // Strobes are forced low while reset is held, whatever the state
        if (reset_n) begin
            case (state_q)
                S_IF: begin
                    mem_phase    = 1'b1;
                    bus.mem_read = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    if (bus.mem_ready) state_d = S_ID;
                end
                S_ID: begin
                    bus.A_write = 1'b1;
                    bus.B_write = 1'b1;
                    if (is_branch) begin
                        bus.alu_src_B = SRCB_IMM;
                        bus.alu_write = 1'b1;
                    end
                    if (is_hlt)                                                    state_d = S_HALT;
                    else if (bus.opcode == OP_LHI || bus.opcode == OP_JAL || is_jrl) state_d = S_WB;
                    else if (bus.opcode == OP_JMP || is_jpr || is_wwd)             state_d = S_PCUP;
                    else                                                           state_d = S_EXE;
                end
                S_EXE: begin
                    bus.alu_src_A = SRCA_A;
                    if (is_branch) begin
                        bus.alu_op    = ALU_SUB;
                        bus.alu_src_B = (bus.opcode == OP_BNE || bus.opcode == OP_BEQ) ? SRCB_B : SRCB_ZERO;
                        bcond_d       = bus.bcond;
`ifdef MC_FAST_BRANCH_EN
                        bus.pc_write  = 1'b1;
                        num_inst_d    = num_inst_q + CNT_ONE;
                        state_d       = S_IF;
                        if (bus.bcond) begin
                            bus.pc_src = PCS_ALUOUT;
                        end else begin
                            bus.alu_src_A = SRCA_PC;
                            bus.alu_src_B = SRCB_ONE;
                            bus.alu_op    = ALU_ADD;
                        end
`else
                        state_d       = S_PCUP;
`endif
                    end else if (is_rtype) begin
                        bus.alu_op    = bus.funccode[2:0];
                        bus.alu_write = 1'b1;
                        state_d       = S_WB;
                    end else begin
                        bus.alu_src_B = SRCB_IMM;
                        bus.alu_op    = (bus.opcode == OP_ORI) ? ALU_ORR : ALU_ADD;
                        bus.alu_write = 1'b1;
                        state_d       = (bus.opcode == OP_LWD || bus.opcode == OP_SWD) ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    mem_phase  = 1'b1;
                    bus.i_or_d = 1'b1;
                    if (bus.opcode == OP_LWD) begin
                        bus.mem_read  = 1'b1;
                        bus.mdr_write = bus.mem_ready;
                    end else begin
                        bus.mem_write = 1'b1;
                    end
                    if (bus.mem_ready) state_d = (bus.opcode == OP_LWD) ? S_WB : S_PCUP;
                end
                S_WB: begin
                    bus.reg_write = 1'b1;
                    state_d       = S_PCUP;
                    if (bus.opcode == OP_ADI || bus.opcode == OP_ORI) begin
                        bus.reg_dst = DST_RT;
                    end else if (bus.opcode == OP_LHI) begin
                        bus.reg_dst    = DST_RT;
                        bus.mem_to_reg = M2R_IMM;
                    end else if (bus.opcode == OP_LWD) begin
                        bus.reg_dst    = DST_RT;
                        bus.mem_to_reg = M2R_MDR;
                    end else if (bus.opcode == OP_JAL || is_jrl) begin
                        bus.reg_dst    = DST_R2;
                        bus.mem_to_reg = M2R_PC;
                    end
                end
                S_PCUP: begin
                    bus.pc_write = 1'b1;
                    num_inst_d   = num_inst_q + CNT_ONE;
                    state_d      = S_IF;
                    if (bus.opcode == OP_JMP || bus.opcode == OP_JAL) begin
                        bus.pc_src = PCS_TARGET;
                    end else if (is_jpr || is_jrl) begin
                        bus.pc_src = PCS_A;
                    end else if (is_branch && bcond_q) begin
                        bus.pc_src = PCS_ALUOUT;
                    end else begin
                        bus.alu_src_B = SRCB_ONE;
                    end
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_HALT;
            endcase

            // The last tolerated low cycle sends the FSM to HALT; a ready
            // on that cycle still completes the access.
            if (mem_phase && !bus.mem_ready) begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = S_HALT;
                    mem_error_d = 1'b1;
                end else begin
                    wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
                end
            end
            if (state_d != state_q) wait_cnt_d = '0;
        end
    end

    assign bus.is_halted = (state_q == S_HALT);
    assign bus.mem_error = mem_error_q;
    assign bus.num_inst  = num_inst_q;
    assign bus.state_o   = state_q;

endmodule

`default_nettype wire
